fab_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared `fab` INIT/FIB/FACT datapath. Each requester submits an (op, in) command with a level request. The arbiter grants one requester at a time and drives fab's `s`/`op`/`in` start handshake. It captures `out` when `done` rises, returns the result with a one-cycle acknowledge, and releases `s` until `done` falls. A per-requester lock keeps a multi-command session (INIT followed by FIB/FACT) from being interleaved with the other requester.

---
 rtl/fab_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fab_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fab_arbiter.sv
// ============================================================================
// fab_arbiter : two-port round-robin arbiter / sequencer for the fab datapath
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fab_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       fab_done,
  input  logic [7:0] fab_out,
  output logic       fab_s,
  output logic [1:0] fab_op,
  output logic [7:0] fab_in,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result,
  output logic       err,
  output logic       owner,
  output logic       busy
);

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_d;
  logic       ptr, ptr_d;
  logic       lock_vld, lock_vld_d;
  logic       lock_id, lock_id_d;
  logic [7:0] cnt, cnt_d;
  logic       fab_s_d, ack0_d, ack1_d, err_d, owner_d;
  logic [1:0] fab_op_d;
  logic [7:0] fab_in_d, result_d;

  logic       gnt_vld, gnt;
  logic [1:0] gnt_op;
  logic       acking, ack_who, ack_err;

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    lock_vld_d = lock_vld;
    lock_id_d  = lock_id;
    cnt_d      = cnt;
    fab_s_d    = fab_s;
    fab_op_d   = fab_op;
    fab_in_d   = fab_in;
    result_d   = result;
    owner_d    = owner;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    gnt_vld    = 1'b0;
    gnt        = ptr;
    gnt_op     = 2'b00;
    acking     = 1'b0;
    ack_who    = owner;
    ack_err    = 1'b0;

    case (state)
      IDLE: begin
        // A held lock restricts arbitration to its owner until released.
        if (lock_vld) begin
          if (lock_id ? req1 : req0) begin
            gnt_vld = 1'b1;
            gnt     = lock_id;
          end else if (!(lock_id ? lock1 : lock0)) begin
            lock_vld_d = 1'b0;
          end
        end else if (req0 && req1) begin
          gnt_vld = 1'b1;
          gnt     = ptr;
        end else if (req0 || req1) begin
          gnt_vld = 1'b1;
          gnt     = req1;
        end

        if (gnt_vld) begin
          gnt_op   = gnt ? op1 : op0;
          fab_op_d = gnt_op;
          fab_in_d = gnt ? in1 : in0;
          owner_d  = gnt;
          if (gnt_op == OP_RSVD) begin
            acking  = 1'b1;
            ack_who = gnt;
            ack_err = 1'b1;
          end else begin
            fab_s_d = 1'b1;
            cnt_d   = 8'd1;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (fab_done) begin
          result_d = fab_out;
          acking   = 1'b1;
          fab_s_d  = 1'b0;
          state_d  = RELEASE;
        end else if (cnt >= TIMEOUT_C) begin
          acking   = 1'b1;
          ack_err  = 1'b1;
          fab_s_d  = 1'b0;
          state_d  = RELEASE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      RELEASE: begin
        if (!fab_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (acking) begin
      ack0_d     = ~ack_who;
      ack1_d     = ack_who;
      err_d      = ack_err;
      lock_vld_d = ack_who ? lock1 : lock0;
      lock_id_d  = ack_who;
      ptr_d      = ~ack_who;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      cnt      <= 8'd0;
      fab_s    <= 1'b0;
      fab_op   <= 2'b00;
      fab_in   <= 8'd0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      result   <= 8'd0;
      err      <= 1'b0;
      owner    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      lock_vld <= lock_vld_d;
      lock_id  <= lock_id_d;
      cnt      <= cnt_d;
      fab_s    <= fab_s_d;
      fab_op   <= fab_op_d;
      fab_in   <= fab_in_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      result   <= result_d;
      err      <= err_d;
      owner    <= owner_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fab_arbiter.sv
// ============================================================================
// tb_fab_arbiter : scoreboard bench for fab_arbiter with a behavioural fab
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fab_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [7:0] in0 = 8'd0, in1 = 8'd0;
  logic       fab_done;
  logic [7:0] fab_out;
  logic       fab_s, ack0, ack1, err, owner, busy;
  logic [1:0] fab_op;
  logic [7:0] fab_in, result;

  int vectors = 0;
  int miscompares = 0;

  fab_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .op0(op0), .op1(op1), .in0(in0), .in1(in1),
    .fab_done(fab_done), .fab_out(fab_out),
    .fab_s(fab_s), .fab_op(fab_op), .fab_in(fab_in),
    .ack0(ack0), .ack1(ack1), .result(result), .err(err),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural fab: INIT n<=in (out 1), FIB fib(n+1), FACT n!.
  logic       stub_hold = 1'b0;
  logic       fab_run;
  int         fab_wait;
  logic [7:0] fab_n;

  function automatic logic [7:0] fib(input int k);
    logic [7:0] a = 8'd0, b = 8'd1, t;
    for (int j = 0; j < k; j++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic logic [7:0] fact(input logic [7:0] n);
    logic [7:0] f = 8'd1;
    for (int j = 2; j <= int'(n); j++) f = f * 8'(j);
    return f;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      fab_done <= 1'b0; fab_out <= 8'd0; fab_run <= 1'b0; fab_wait <= 0; fab_n <= 8'd0;
    end else if (!fab_s) begin
      fab_done <= 1'b0; fab_run <= 1'b0;
    end else if (!fab_run) begin
      fab_run <= 1'b1; fab_wait <= 2;
    end else if (fab_wait > 0) begin
      fab_wait <= fab_wait - 1;
    end else if (!stub_hold && !fab_done) begin
      fab_done <= 1'b1;
      case (fab_op)
        2'b00: begin fab_n <= fab_in; fab_out <= 8'd1; end
        2'b01: fab_out <= fib(int'(fab_n) + 1);
        2'b10: fab_out <= fact(fab_n);
        default: fab_out <= 8'd0;
      endcase
    end
  end

  typedef struct { logic [1:0] op; logic [7:0] din; logic lk; } cmd_t;
  typedef struct { logic who; logic [7:0] res; logic e; } exp_t;
  cmd_t cq0[$], cq1[$];
  exp_t exp_q[$];

  // Presents queued commands, drops req after each ack, pops and compares.
  task automatic run(input int start1, input int budget, output int s_hi);
    int   cyc = 0;
    bit   hold0 = 0, hold1 = 0, prev_ack = 0, prev_s = 0;
    cmd_t c;
    exp_t e;
    s_hi = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (fab_s) s_hi++;
      if (fab_s && !prev_s) begin
        vectors++;
        if (fab_done !== 1'b0) begin
          miscompares++;
          $display("FAIL s_while_done: fab_done=%b at fab_s rise, want 0", fab_done);
        end
      end
      prev_s = fab_s;
      if (!req0 && !hold0 && cq0.size() != 0) begin
        c = cq0.pop_front(); op0 = c.op; in0 = c.din; lock0 = c.lk; req0 = 1'b1;
      end
      if (!req1 && !hold1 && cq1.size() != 0 && cyc >= start1) begin
        c = cq1.pop_front(); op1 = c.op; in1 = c.din; lock1 = c.lk; req1 = 1'b1;
      end
      hold0 = 0; hold1 = 0;
      if (ack0 || ack1) begin
        e = exp_q.pop_front();
        vectors++;
        if ({ack1, result, err} !== {e.who, e.res, e.e} || (ack0 && ack1)) begin
          miscompares++;
          $display("FAIL ack: who=%b%b result=%0d err=%b, want who=%b result=%0d err=%b",
                   ack1, ack0, result, err, e.who, e.res, e.e);
        end
        vectors++;
        if (fab_s !== 1'b0) begin
          miscompares++;
          $display("FAIL s_in_ack: fab_s=%b, want 0", fab_s);
        end
        vectors++;
        if (prev_ack) begin
          miscompares++;
          $display("FAIL ack_width: ack high two cycles, want one");
        end
        if (ack1) begin
          req1 = 1'b0; hold1 = 1; if (cq1.size() == 0) lock1 = 1'b0;
        end else begin
          req0 = 1'b0; hold0 = 1; if (cq0.size() == 0) lock0 = 1'b0;
        end
      end
      prev_ack = ack0 || ack1;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL run_timeout: %0d acks outstanding, want 0", exp_q.size());
      exp_q.delete(); cq0.delete(); cq1.delete();
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fab_s, fab_op, fab_in, ack0, ack1, result, err, owner, busy} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: %h, want 0",
               {fab_s, fab_op, fab_in, ack0, ack1, result, err, owner, busy});
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fab_s || ack0 || ack1 || busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_fib_sequence();
    int s;
    cq0.push_back('{2'b00, 8'd4, 1'b0}); exp_q.push_back('{1'b0, 8'd1, 1'b0});
    cq0.push_back('{2'b01, 8'd0, 1'b0}); exp_q.push_back('{1'b0, 8'd5, 1'b0});
    run(1, 200, s);
  endtask

  task automatic test_round_robin();
    int s;
    pulse_reset();
    // After reset the pointer favours 0: INIT 5 then FIB gives fib(6)=8.
    cq0.push_back('{2'b00, 8'd5, 1'b0}); exp_q.push_back('{1'b0, 8'd1, 1'b0});
    cq1.push_back('{2'b01, 8'd0, 1'b0}); exp_q.push_back('{1'b1, 8'd8, 1'b0});
    run(1, 200, s);
    cq0.push_back('{2'b00, 8'd4, 1'b0}); exp_q.push_back('{1'b0, 8'd1, 1'b0});
    run(1, 200, s);
    // Requester 0 served last, so 1 wins: INIT 2 then FACT gives 2.
    cq0.push_back('{2'b10, 8'd0, 1'b0});
    cq1.push_back('{2'b00, 8'd2, 1'b0}); exp_q.push_back('{1'b1, 8'd1, 1'b0});
    exp_q.push_back('{1'b0, 8'd2, 1'b0});
    run(1, 200, s);
  endtask

  task automatic test_lock();
    int s;
    cq0.push_back('{2'b00, 8'd3, 1'b1}); exp_q.push_back('{1'b0, 8'd1, 1'b0});
    cq0.push_back('{2'b10, 8'd0, 1'b0}); exp_q.push_back('{1'b0, 8'd6, 1'b0});
    cq1.push_back('{2'b01, 8'd0, 1'b0}); exp_q.push_back('{1'b1, 8'd3, 1'b0});
    run(2, 300, s);
  endtask

  task automatic test_timeout();
    int s;
    stub_hold = 1'b1;
    cq0.push_back('{2'b01, 8'd0, 1'b0}); exp_q.push_back('{1'b0, 8'd3, 1'b1});
    run(1, 100, s);
    vectors++;
    if (s != 8) begin
      miscompares++;
      $display("FAIL timeout_len: fab_s high %0d cycles, want 8", s);
    end
    stub_hold = 1'b0;
    cq1.push_back('{2'b11, 8'd9, 1'b0}); exp_q.push_back('{1'b1, 8'd3, 1'b1});
    run(1, 50, s);
    vectors++;
    if (s != 0) begin
      miscompares++;
      $display("FAIL op11_no_start: fab_s high %0d cycles, want 0", s);
    end
  endtask

  task automatic test_reset_mid();
    int s, n = 0;
    stub_hold = 1'b1;
    @(negedge clk); op0 = 2'b01; in0 = 8'd0; req0 = 1'b1;
    while (!fab_s && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (fab_s !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_grant: fab_s=%b, want 1", fab_s);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({fab_s, fab_op, fab_in, ack0, ack1, result, err, owner, busy} !== 24'd0) begin
      miscompares++;
      $display("FAIL mid_reset: %h, want 0",
               {fab_s, fab_op, fab_in, ack0, ack1, result, err, owner, busy});
    end
    stub_hold = 1'b0;
    cq1.push_back('{2'b00, 8'd7, 1'b0}); exp_q.push_back('{1'b1, 8'd1, 1'b0});
    run(1, 100, s);
  endtask

  initial begin
    test_reset();
    test_fib_sequence();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
